// File: rtl/slt_minmax_tracker_if.sv
// Stream interface for slt_minmax_tracker: sample input channel and frame
// result output channel. O_ARGMIN exists only when SLT_MINMAX_ARGMIN_EN is
// defined.
interface slt_minmax_tracker_if #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = 8
);
  logic                 I_VALID;
  logic                 I_READY;
  logic [WIDTH-1:0]     I;
  logic                 I_LAST;
  logic                 O_VALID;
  logic                 O_READY;
  logic [WIDTH-1:0]     O_MIN;
  logic [WIDTH-1:0]     O_MAX;
  logic [CNT_WIDTH-1:0] O_COUNT;
`ifdef SLT_MINMAX_ARGMIN_EN
  logic [CNT_WIDTH-1:0] O_ARGMIN;
`endif

  // Sample source / result consumer side.
  modport master (
`ifdef SLT_MINMAX_ARGMIN_EN
    input  O_ARGMIN,
`endif
    output I_VALID, I, I_LAST, O_READY,
    input  I_READY, O_VALID, O_MIN, O_MAX, O_COUNT
  );

  // Tracker side.
  modport slave (
`ifdef SLT_MINMAX_ARGMIN_EN
    output O_ARGMIN,
`endif
    input  I_VALID, I, I_LAST, O_READY,
    output I_READY, O_VALID, O_MIN, O_MAX, O_COUNT
  );
endinterface

// File: rtl/slt_minmax_tracker.sv
// slt_minmax_tracker: per-frame signed min / max / sample count of a framed
// stream. Comparisons use the subtract-and-correct-for-overflow signed
// less-than. One result per frame is held until the consumer takes it.
// Optional macro SLT_MINMAX_ARGMIN_EN adds O_ARGMIN, the 0-based index of
// the first occurrence of the frame minimum.
module slt_minmax_tracker #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input logic                 CLK,
  input logic                 RESET,
  slt_minmax_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     min_q, min_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     out_min_q, out_min_d;
  logic [WIDTH-1:0]     out_max_q, out_max_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
`ifdef SLT_MINMAX_ARGMIN_EN
  logic [CNT_WIDTH-1:0] argmin_q, argmin_d;
  logic [CNT_WIDTH-1:0] out_argmin_q, out_argmin_d;
`endif

  logic i_ready;
  logic o_valid;
  logic accept;
  logic handoff;
  logic close_frame;

  // Signed a < b: the sign of a - b, flipped when the subtraction overflowed
  // (operands of different sign and a result sign differing from a).
  function automatic logic slt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    logic             ovf;
    d   = a - b;
    ovf = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    return d[WIDTH-1] ^ ovf;
  endfunction

  assign accept      = bus.I_VALID && i_ready;
  assign handoff     = o_valid && bus.O_READY;
  assign close_frame = accept && bus.I_LAST;

  // State register and all datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      min_q        <= '0;
      max_q        <= '0;
      cnt_q        <= '0;
      out_min_q    <= '0;
      out_max_q    <= '0;
      out_cnt_q    <= '0;
`ifdef SLT_MINMAX_ARGMIN_EN
      argmin_q     <= '0;
      out_argmin_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      min_q        <= min_d;
      max_q        <= max_d;
      cnt_q        <= cnt_d;
      out_min_q    <= out_min_d;
      out_max_q    <= out_max_d;
      out_cnt_q    <= out_cnt_d;
`ifdef SLT_MINMAX_ARGMIN_EN
      argmin_q     <= argmin_d;
      out_argmin_q <= out_argmin_d;
`endif
    end
  end

  // Next-state logic: frame opens on first accept, closes on the I_LAST beat.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (close_frame) state_d = DONE;
        else if (accept) state_d = ACCUM;
      end
      DONE: begin
        if (handoff) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Running min/max/count update, and capture into the result registers on
  // the closing beat so the result is visible the cycle after it.
  always_comb begin
    min_d     = min_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    out_min_d = out_min_q;
    out_max_d = out_max_q;
    out_cnt_d = out_cnt_q;
`ifdef SLT_MINMAX_ARGMIN_EN
    argmin_d     = argmin_q;
    out_argmin_d = out_argmin_q;
`endif
    if (accept) begin
      if (state_q == IDLE) begin
        min_d = bus.I;
        max_d = bus.I;
        cnt_d = CNT_ONE;
`ifdef SLT_MINMAX_ARGMIN_EN
        argmin_d = '0;
`endif
      end else begin
        // Strict compares: ties keep the stored value (first occurrence wins).
        if (slt(bus.I, min_q)) begin
          min_d = bus.I;
`ifdef SLT_MINMAX_ARGMIN_EN
          // cnt_q is the 0-based index of this beat, saturating with the count.
          argmin_d = cnt_q;
`endif
        end
        if (slt(max_q, bus.I)) max_d = bus.I;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      end
    end
    if (close_frame) begin
      out_min_d = min_d;
      out_max_d = max_d;
      out_cnt_d = cnt_d;
`ifdef SLT_MINMAX_ARGMIN_EN
      out_argmin_d = argmin_d;
`endif
    end
  end

  // Handshake outputs decoded from registered state only.
  always_comb begin
    i_ready = (state_q != DONE);
    o_valid = (state_q == DONE);
  end

  assign bus.I_READY  = i_ready;
  assign bus.O_VALID  = o_valid;
  assign bus.O_MIN    = out_min_q;
  assign bus.O_MAX    = out_max_q;
  assign bus.O_COUNT  = out_cnt_q;
`ifdef SLT_MINMAX_ARGMIN_EN
  assign bus.O_ARGMIN = out_argmin_q;
`endif

endmodule

// File: doc/slt_minmax_tracker.md
Name: slt_minmax_tracker

Overview:
- Streaming stage directly downstream of the 2-bit signed less-than comparator.
- Accepts a framed stream of signed samples and produces one registered result per frame: running minimum, running maximum and sample count.
- Min/max decisions use the same signed-less-than function: subtract, then XOR the sign bit with the overflow bit.
- Sits between the J1 sample source and result consumers in ice40 test designs.

Parameters:
- WIDTH, 2, sample width in bits, two's complement signed.
- CNT_WIDTH, 8, width of the sample counter and of the index output.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- I_VALID  input  1  an input sample is present.
- I_READY  output  1  the block accepts a sample this cycle.
- I  input  WIDTH  signed input sample.
- I_LAST  input  1  marks the final sample of a frame; qualified by I_VALID.
- O_VALID  output  1  a frame result is held on the outputs.
- O_READY  input  1  the consumer accepts the result.
- O_MIN  output  WIDTH  signed minimum of the frame.
- O_MAX  output  WIDTH  signed maximum of the frame.
- O_COUNT  output  CNT_WIDTH  number of samples in the frame (saturating).

Behaviour:
- Accept = I_VALID && I_READY.
- Result handoff = O_VALID && O_READY.
- States:
  - IDLE: no sample accepted yet in the current frame.
  - ACCUM: at least one sample accepted, frame still open.
  - DONE: result is held.
- I_READY = 1 in IDLE and ACCUM, 0 in DONE. I_READY is driven from registered state only; it is never combinational on I_VALID.
- IDLE, on accept:
  - min_r = I, max_r = I, cnt_r = 1.
  - Next state is DONE if I_LAST, otherwise ACCUM.
- ACCUM, on accept:
  - If slt(I, min_r), then min_r = I.
  - If slt(max_r, I), then max_r = I.
  - cnt_r = cnt_r + 1, saturating at 2^CNT_WIDTH-1.
  - Next state is DONE if I_LAST.
- Ties: comparison is strict, so equal values never replace the stored value.
- slt(a, b): compute d = a - b at WIDTH+0 bits. Result = d[WIDTH-1] XOR ((a[MSB] != b[MSB]) && (d[MSB] != a[MSB])). It must be correct at every overflow corner, e.g. slt(1, -2) = 0 and slt(-2, 1) = 1 for WIDTH=2.
- DONE:
  - O_VALID = 1; O_MIN, O_MAX and O_COUNT are stable and equal to min_r, max_r and cnt_r.
  - On handoff, go to IDLE. O_VALID drops the next cycle; output data holds its last value.
- No accept and no handoff: state and registers hold.
- Latency: O_VALID rises on the clock edge that accepts the I_LAST beat, so it is visible the cycle after that accept.
- Throughput: I_READY is 0 for at least one cycle per frame (the DONE cycle), so there is one bubble per frame.
- O_MIN, O_MAX and O_COUNT are outputs of registers, not combinational.
- Reset (asynchronous, any time including mid-frame):
  - State goes to IDLE; the partial frame is discarded.
  - O_VALID = 0, O_MIN = 0, O_MAX = 0, O_COUNT = 0.
  - I_READY = 1 once reset is released.
- I_LAST without I_VALID is ignored. X on I is ignored when I_VALID = 0.

Optional Feature:
- Macro: SLT_MINMAX_ARGMIN_EN.
- Defined:
  - Adds output port O_ARGMIN, width CNT_WIDTH: the 0-based index within the frame of the first occurrence of the minimum.
  - Set to 0 on the first accept; updated to the current index whenever min_r is replaced.
  - The index counter saturates with cnt_r.
  - Reset value is 0; held through DONE.
- Undefined: the port and all its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=2 unless stated):
- Reset, then frame 1, -2, 0, -1 (last), O_READY=1 -> one cycle after last accept: O_VALID=1, O_MIN=2'b10, O_MAX=2'b01, O_COUNT=4; O_ARGMIN=1 if enabled.
- Single-beat frame -1 with I_LAST -> next cycle O_VALID=1, O_MIN=O_MAX=2'b11, O_COUNT=1.
- Overflow corner, frame -2, 1 then frame 1, -2 -> both give O_MIN=-2, O_MAX=1.
- Backpressure: O_READY=0 for 5 cycles after DONE while I_VALID=1 with value 0 -> O_VALID held, I_READY=0, outputs unchanged; next frame unaffected by the ignored samples.
- Ties, frame 0, -2, -2, 1 -> O_MIN=-2, O_ARGMIN=1. Saturation with CNT_WIDTH=2: 6-beat frame -> O_COUNT=3.
- RESET pulsed after 2 beats of a frame -> O_VALID=0 and all outputs 0; next frame of 3 beats reports O_COUNT=3.
